// File: rtl/fir_sample_scheduler.sv
// -----------------------------------------------------------------------------
// fir_sample_scheduler
//
// Sequences the polyphase interpolation FIR stage. Incoming stereo PCM pairs
// are buffered in a small FIFO. Once the FIFO holds PRIME pairs, the first pair
// is presented on x_0/x_1 and the FIR start is raised. After that, a new pair is
// presented once per input frame of (2^osr_active)*128 pclk cycles. out_strobe
// pulses once per 128-cycle output slot while the FIR reports valid outputs.
// An underrun (an empty FIFO at a frame end) mutes the FIR input and sets a
// sticky flag. A disable or a change of ratio flushes the block back to IDLE.
//
// Ports:
//   pclk           in   clock
//   reset_n        in   asynchronous active-low reset
//   enable         in   run request; 0 returns to IDLE
//   oversampling_x in   [1:0] requested ratio (1x/2x/4x/8x), taken in IDLE
//   in_valid       in   input pair valid
//   in_ready       out  FIFO can accept a pair
//   in_l, in_r     in   [31:0] left/right input sample
//   started        in   FIR "outputs valid" indication
//   start          out  FIR start/run enable
//   x_0, x_1       out  [31:0] left/right sample presented to the FIR
//   osr_active     out  [1:0] latched ratio driving the FIR
//   out_strobe     out  one-cycle pulse when the FIR outputs are updated
//   underrun       out  sticky underrun flag
//   underrun_clr   in   clears underrun (a coincident set wins)
// -----------------------------------------------------------------------------
module fir_sample_scheduler #(
  parameter int DEPTH = 4,  // FIFO depth in stereo pairs, power of 2, >= 2
  parameter int PRIME = 2   // occupancy needed before start, 1..DEPTH
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  oversampling_x,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  input  logic        started,
  output logic        start,
  output logic [31:0] x_0,
  output logic [31:0] x_1,
  output logic [1:0]  osr_active,
  output logic        out_strobe,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [2:0]      ph_q, ph_d;
  logic [1:0]      osr_q, osr_d;
  logic [31:0]     x0_q, x0_d;
  logic [31:0]     x1_q, x1_d;
  logic            strobe_q, strobe_d;
  logic            underrun_q, underrun_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     mem_l [DEPTH];
  logic [31:0]     mem_r [DEPTH];

  logic            push;
  logic            pop;
  logic            set_ur;
  logic            flush;
  logic            fifo_empty;
  logic            frame_end;
  logic [2:0]      last_k;

  // Last phase index of a frame: 2^osr - 1.
  always_comb begin
    last_k = 3'd0;
    case (osr_q)
      2'd0: last_k = 3'd0;
      2'd1: last_k = 3'd1;
      2'd2: last_k = 3'd3;
      2'd3: last_k = 3'd7;
      default: last_k = 3'd0;
    endcase
  end

  assign in_ready   = (count_q != CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  // Leaving FILL/RUN on disable or on a ratio change; both look identical.
  assign flush      = (state_q != IDLE) &&
                      (!enable || (oversampling_x != osr_q));
  assign frame_end  = (state_q == RUN) && (cnt_q == 7'd127) && (ph_q == last_k);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    osr_d      = osr_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop        = 1'b0;
    set_ur     = 1'b0;
    push       = in_valid && in_ready && !flush;

    case (state_q)
      IDLE: begin
        cnt_d = 7'd0;
        ph_d  = 3'd0;
        osr_d = oversampling_x;
        if (enable) state_d = FILL;
      end
      FILL: begin
        if (count_q >= CW'(PRIME)) begin
          pop     = 1'b1;
          x0_d    = mem_l[rd_ptr_q];
          x1_d    = mem_r[rd_ptr_q];
          cnt_d   = 7'd0;
          ph_d    = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127) ph_d = (ph_q == last_k) ? 3'd0 : ph_q + 3'd1;
        if (frame_end) begin
          if (!fifo_empty) begin
            pop  = 1'b1;
            x0_d = mem_l[rd_ptr_q];
            x1_d = mem_r[rd_ptr_q];
          end else begin
            // Starved: feed silence rather than repeating a stale sample.
            x0_d   = 32'd0;
            x1_d   = 32'd0;
            set_ur = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      cnt_d    = 7'd0;
      ph_d     = 3'd0;
      x0_d     = 32'd0;
      x1_d     = 32'd0;
      pop      = 1'b0;
      set_ur   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // The strobe marks the slot after each cnt==127 cycle, gated by the FIR
  // reporting valid outputs in that cycle.
  assign strobe_d   = (state_q == RUN) && (cnt_q == 7'd127) && started;
  assign underrun_d = set_ur ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 7'd0;
      ph_q       <= 3'd0;
      osr_q      <= 2'd0;
      x0_q       <= 32'd0;
      x1_q       <= 32'd0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      osr_q      <= osr_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the sample storage has no reset; the pointers and count define which
  // entries are valid, so the contents never need clearing.
  always_ff @(posedge pclk) begin
    if (push) begin
      mem_l[wr_ptr_q] <= in_l;
      mem_r[wr_ptr_q] <= in_r;
    end
  end

  // start is decoded from the registered state, so it falls with reset_n.
  assign start      = (state_q == RUN);
  assign x_0        = x0_q;
  assign x_1        = x1_q;
  assign osr_active = osr_q;
  assign out_strobe = strobe_q;
  assign underrun   = underrun_q;

endmodule
